// File: rtl/axi_mst_wdriver_v2.sv
// axi_mst_wdriver_v2
//   AXI4 master write-data driver for bench use. Observes AW handshakes
//   from the sequencer, queues them, and replays one W burst per queued AW
//   in order, with per-beat strobes derived from AWSIZE/AWADDR, optional
//   LFSR throttling of WVALID, and B-response credit accounting.
//
// Ports
//   aclk, srst                 clock, synchronous active-high reset
//   in_aw*                     observed AW channel (valid/ready/id/len/size/addr low bits)
//   aw_credit_ok               a new AW may be issued (outstanding and queue room)
//   throttle_en, bready_mode   W throttling enable, B ready source select
//   out_w*, in_wready          generated W channel
//   in_bvalid, out_bready      B channel handshake
//   err_overflow, err_bunexp   sticky error flags
module axi_mst_wdriver_v2 #(
    parameter int unsigned AXI_ID_W   = 32'd4,
    parameter int unsigned AXI_DATA_W = 32'd32,
    parameter int unsigned OSTD_NUM   = 32'd4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                                aclk,
    input  logic                                srst,
    input  logic                                in_awvalid,
    input  logic                                in_awready,
    input  logic [AXI_ID_W-1:0]                 in_awid,
    input  logic [7:0]                          in_awlen,
    input  logic [2:0]                          in_awsize,
    input  logic [$clog2(AXI_DATA_W/32'd8)-1:0] in_awaddr_lo,
    output logic                                aw_credit_ok,
    input  logic                                throttle_en,
    input  logic                                bready_mode,
    output logic                                out_wvalid,
    input  logic                                in_wready,
    output logic                                out_wlast,
    output logic [AXI_ID_W-1:0]                 out_wid,
    output logic [AXI_DATA_W-1:0]               out_wdata,
    output logic [AXI_DATA_W/8-1:0]             out_wstrb,
    input  logic                                in_bvalid,
    output logic                                out_bready,
    output logic                                err_overflow,
    output logic                                err_bunexp
);

    localparam int unsigned STRB_W = AXI_DATA_W / 32'd8;
    localparam int unsigned AL_W   = $clog2(STRB_W);
    localparam int unsigned PTR_W  = $clog2(OSTD_NUM);
    localparam int unsigned CNT_W  = PTR_W + 32'd1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } w_state_e;

    // Byte strobes of one beat. Beat 0 starts at the (possibly unaligned)
    // address; later beats cover a full size-aligned slot that walks the bus.
    function automatic logic [STRB_W-1:0] beat_strb(
        input logic [2:0]      size,
        input logic [AL_W-1:0] addr_lo,
        input logic [7:0]      beat
    );
        logic [31:0] nb;
        logic [31:0] base;
        logic [31:0] start;
        logic [31:0] first;
        nb    = 32'd1 << size;
        base  = {{(32-AL_W){1'b0}}, addr_lo} & ~(nb - 32'd1);
        start = (base + {24'd0, beat} * nb) % STRB_W;
        first = (beat == 8'd0) ? {{(32-AL_W){1'b0}}, addr_lo} : start;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            beat_strb[b] = (b >= first) && (b < start + nb);
        end
    endfunction

    // Beat payload: the word counter copied into every 32-bit lane, with
    // bytes outside the strobe forced to zero.
    function automatic logic [AXI_DATA_W-1:0] beat_data(
        input logic [31:0]       word,
        input logic [STRB_W-1:0] strb
    );
        for (int unsigned b = 0; b < STRB_W; b++) begin
            beat_data[b*32'd8 +: 8] = strb[b] ? word[(b % 32'd4)*32'd8 +: 8] : 8'd0;
        end
    endfunction

    // AW queue storage
    logic [AXI_ID_W-1:0] q_id_r   [OSTD_NUM];
    logic [7:0]          q_len_r  [OSTD_NUM];
    logic [2:0]          q_size_r [OSTD_NUM];
    logic [AL_W-1:0]     q_addr_r [OSTD_NUM];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    q_cnt_r;
    logic [CNT_W-1:0]    ostd_cnt_r;

    // W channel state and registered outputs
    w_state_e            state_r;
    w_state_e            state_nxt_s;
    logic [7:0]          beat_cnt_r;
    logic [31:0]         word_cnt_r;
    logic                wvalid_r;
    logic                wlast_r;
    logic [AXI_ID_W-1:0] wid_r;
    logic [AXI_DATA_W-1:0] wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                bready_r;
    logic                err_ovf_r;
    logic                err_bun_r;
    logic [15:0]         lfsr_r;

    // Next-value signals
    logic                aw_hs_s;
    logic                q_full_s;
    logic                push_s;
    logic                w_hs_s;
    logic                pop_s;
    logic                b_hs_s;
    logic                b_dec_s;
    logic                throttled_s;
    logic [PTR_W-1:0]    rd_nxt_s;
    logic [7:0]          beat_nxt_s;
    logic [31:0]         word_nxt_s;
    logic                wvalid_nxt_s;
    logic                wlast_nxt_s;
    logic [AXI_ID_W-1:0] wid_nxt_s;
    logic [STRB_W-1:0]   wstrb_nxt_s;
    logic [AXI_DATA_W-1:0] wdata_nxt_s;
    logic [CNT_W-1:0]    ostd_nxt_s;

    assign aw_hs_s  = in_awvalid && in_awready;
    assign q_full_s = (q_cnt_r == CNT_W'(OSTD_NUM));
    assign push_s   = aw_hs_s && !q_full_s;
    assign w_hs_s   = wvalid_r && in_wready;
    assign pop_s    = w_hs_s && wlast_r;
    assign b_hs_s   = in_bvalid && bready_r;
    assign b_dec_s  = b_hs_s && (ostd_cnt_r != {CNT_W{1'b0}});

    assign aw_credit_ok = (ostd_cnt_r < CNT_W'(OSTD_NUM)) && !q_full_s;
    assign out_wvalid   = wvalid_r;
    assign out_wlast    = wlast_r;
    assign out_wid      = wid_r;
    assign out_wdata    = wdata_r;
    assign out_wstrb    = wstrb_r;
    assign out_bready   = bready_r;
    assign err_overflow = err_ovf_r;
    assign err_bunexp   = err_bun_r;

    // Queue payload write; storage needs no reset since q_cnt_r gates its use
    always_ff @(posedge aclk) begin
        if (push_s) begin
            q_id_r[wr_ptr_r]   <= in_awid;
            q_len_r[wr_ptr_r]  <= in_awlen;
            q_size_r[wr_ptr_r] <= in_awsize;
            q_addr_r[wr_ptr_r] <= in_awaddr_lo;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            q_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r <= rd_nxt_s;
            if (push_s && !pop_s) begin
                q_cnt_r <= q_cnt_r + CNT_W'(1'b1);
            end else if (!push_s && pop_s) begin
                q_cnt_r <= q_cnt_r - CNT_W'(1'b1);
            end
        end
    end

    // Outstanding-transaction count: AW accept adds, B handshake retires
    always_comb begin
        ostd_nxt_s = ostd_cnt_r;
        if (push_s && !b_dec_s) begin
            ostd_nxt_s = ostd_cnt_r + CNT_W'(1'b1);
        end else if (!push_s && b_dec_s) begin
            ostd_nxt_s = ostd_cnt_r - CNT_W'(1'b1);
        end else begin
            ostd_nxt_s = ostd_cnt_r;
        end
    end

    // Credit counter, sticky error flags, B ready and throttle LFSR
    always_ff @(posedge aclk) begin
        if (srst) begin
            ostd_cnt_r <= {CNT_W{1'b0}};
            err_ovf_r  <= 1'b0;
            err_bun_r  <= 1'b0;
            bready_r   <= !bready_mode;
            lfsr_r     <= LFSR_SEED;
        end else begin
            ostd_cnt_r <= ostd_nxt_s;
            if (aw_hs_s && q_full_s) begin
                err_ovf_r <= 1'b1;
            end
            if (b_hs_s && (ostd_cnt_r == {CNT_W{1'b0}})) begin
                err_bun_r <= 1'b1;
            end
            bready_r <= bready_mode ? lfsr_r[1] : 1'b1;
            // Fibonacci form of x^16+x^14+x^13+x^11, shifting toward bit 0
            lfsr_r   <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
        end
    end

    // W FSM state register
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // W FSM next state. An AW pushed in the same cycle as the final pop is
    // not yet readable from storage, so it starts after one IDLE cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (q_cnt_r != {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (pop_s && (q_cnt_r == CNT_W'(1'b1))) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // W FSM outputs: hold a pending beat, else present the next beat of the
    // head burst (the following burst right after a pop), else go idle
    always_comb begin
        word_nxt_s   = word_cnt_r;
        beat_nxt_s   = beat_cnt_r;
        rd_nxt_s     = rd_ptr_r;
        throttled_s  = throttle_en && !lfsr_r[0];
        wvalid_nxt_s = wvalid_r;
        wlast_nxt_s  = wlast_r;
        wid_nxt_s    = wid_r;
        wstrb_nxt_s  = wstrb_r;
        wdata_nxt_s  = wdata_r;
        if (w_hs_s) begin
            word_nxt_s = word_cnt_r + 32'd1;
            if (wlast_r) begin
                beat_nxt_s = 8'd0;
            end else begin
                beat_nxt_s = beat_cnt_r + 8'd1;
            end
        end else begin
            word_nxt_s = word_cnt_r;
            beat_nxt_s = beat_cnt_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        if (wvalid_r && !in_wready) begin
            wvalid_nxt_s = 1'b1;
        end else if ((state_nxt_s == ST_BURST) && !throttled_s) begin
            wvalid_nxt_s = 1'b1;
            wlast_nxt_s  = (beat_nxt_s == q_len_r[rd_nxt_s]);
            wid_nxt_s    = q_id_r[rd_nxt_s];
            wstrb_nxt_s  = beat_strb(q_size_r[rd_nxt_s], q_addr_r[rd_nxt_s], beat_nxt_s);
            wdata_nxt_s  = beat_data(word_nxt_s, wstrb_nxt_s);
        end else begin
            wvalid_nxt_s = 1'b0;
            wlast_nxt_s  = 1'b0;
            wid_nxt_s    = {AXI_ID_W{1'b0}};
            wstrb_nxt_s  = {STRB_W{1'b0}};
            wdata_nxt_s  = {AXI_DATA_W{1'b0}};
        end
    end

    // W output registers and beat/word counters; reset drops any burst in flight
    always_ff @(posedge aclk) begin
        if (srst) begin
            beat_cnt_r <= 8'd0;
            word_cnt_r <= 32'd0;
            wvalid_r   <= 1'b0;
            wlast_r    <= 1'b0;
            wid_r      <= {AXI_ID_W{1'b0}};
            wstrb_r    <= {STRB_W{1'b0}};
            wdata_r    <= {AXI_DATA_W{1'b0}};
        end else begin
            beat_cnt_r <= beat_nxt_s;
            word_cnt_r <= word_nxt_s;
            wvalid_r   <= wvalid_nxt_s;
            wlast_r    <= wlast_nxt_s;
            wid_r      <= wid_nxt_s;
            wstrb_r    <= wstrb_nxt_s;
            wdata_r    <= wdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_axi_mst_wdriver_v2.sv
// tb_axi_mst_wdriver_v2
//   Directed bench for axi_mst_wdriver_v2: a 32-bit instance for the main
//   scenarios and a 64-bit instance for narrow/unaligned strobes. Inputs are
//   driven and outputs sampled on the falling edge of aclk.
module tb_axi_mst_wdriver_v2;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic srst;
    logic throttle_en;
    logic bready_mode;

    // 32-bit instance
    logic        awvalid, awready, wready, bvalid;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awaddr_lo;
    logic        credit, wvalid, wlast, bready, err_ovf, err_bun;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    // 64-bit instance
    logic        h_awvalid, h_awready, h_wready, h_bvalid;
    logic [3:0]  h_awid;
    logic [7:0]  h_awlen;
    logic [2:0]  h_awsize;
    logic [2:0]  h_awaddr_lo;
    logic        h_credit, h_wvalid, h_wlast, h_bready, h_err_ovf, h_err_bun;
    logic [3:0]  h_wid;
    logic [63:0] h_wdata;
    logic [7:0]  h_wstrb;

    int tests;
    int fails;

    axi_mst_wdriver_v2 #(.AXI_ID_W(4), .AXI_DATA_W(32), .OSTD_NUM(4), .LFSR_SEED(16'hACE1)) dut (
        .aclk(aclk), .srst(srst),
        .in_awvalid(awvalid), .in_awready(awready), .in_awid(awid), .in_awlen(awlen),
        .in_awsize(awsize), .in_awaddr_lo(awaddr_lo), .aw_credit_ok(credit),
        .throttle_en(throttle_en), .bready_mode(bready_mode),
        .out_wvalid(wvalid), .in_wready(wready), .out_wlast(wlast), .out_wid(wid),
        .out_wdata(wdata), .out_wstrb(wstrb), .in_bvalid(bvalid), .out_bready(bready),
        .err_overflow(err_ovf), .err_bunexp(err_bun)
    );

    axi_mst_wdriver_v2 #(.AXI_ID_W(4), .AXI_DATA_W(64), .OSTD_NUM(4), .LFSR_SEED(16'hACE1)) dut64 (
        .aclk(aclk), .srst(srst),
        .in_awvalid(h_awvalid), .in_awready(h_awready), .in_awid(h_awid), .in_awlen(h_awlen),
        .in_awsize(h_awsize), .in_awaddr_lo(h_awaddr_lo), .aw_credit_ok(h_credit),
        .throttle_en(throttle_en), .bready_mode(bready_mode),
        .out_wvalid(h_wvalid), .in_wready(h_wready), .out_wlast(h_wlast), .out_wid(h_wid),
        .out_wdata(h_wdata), .out_wstrb(h_wstrb), .in_bvalid(h_bvalid), .out_bready(h_bready),
        .err_overflow(h_err_ovf), .err_bunexp(h_err_bun)
    );

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic clear_inputs();
        awvalid = 1'b0; awready = 1'b0; awid = 4'd0; awlen = 8'd0; awsize = 3'd0; awaddr_lo = 2'd0;
        wready = 1'b0; bvalid = 1'b0;
        h_awvalid = 1'b0; h_awready = 1'b0; h_awid = 4'd0; h_awlen = 8'd0; h_awsize = 3'd0;
        h_awaddr_lo = 3'd0; h_wready = 1'b0; h_bvalid = 1'b0;
        throttle_en = 1'b0; bready_mode = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        clear_inputs();
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic aw32(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] lo);
        awvalid = 1'b1; awready = 1'b1; awid = id; awlen = len; awsize = size; awaddr_lo = lo;
        tick();
        awvalid = 1'b0; awready = 1'b0;
    endtask

    task automatic aw64(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                        input logic [2:0] lo);
        h_awvalid = 1'b1; h_awready = 1'b1; h_awid = id; h_awlen = len; h_awsize = size;
        h_awaddr_lo = lo;
        tick();
        h_awvalid = 1'b0; h_awready = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        clear_inputs();
        tick();
        tick();
        tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid: got %0b exp 0", wvalid); end
        tests++; if (wlast !== 1'b0) begin fails++; $display("FAIL reset_wlast: got %0b exp 0", wlast); end
        tests++; if (wstrb !== 4'h0 || wdata !== 32'h0 || wid !== 4'h0) begin
            fails++; $display("FAIL reset_payload: strb %h data %h id %h exp all 0", wstrb, wdata, wid);
        end
        tests++; if (credit !== 1'b1 || h_credit !== 1'b1) begin
            fails++; $display("FAIL reset_credit: got %0b/%0b exp 1/1", credit, h_credit);
        end
        tests++; if (bready !== 1'b1) begin fails++; $display("FAIL reset_bready_mode0: got %0b exp 1", bready); end
        tests++; if (err_ovf !== 1'b0 || err_bun !== 1'b0) begin
            fails++; $display("FAIL reset_errors: got %0b/%0b exp 0/0", err_ovf, err_bun);
        end
        bready_mode = 1'b1;
        tick();
        tests++; if (bready !== 1'b0) begin fails++; $display("FAIL reset_bready_mode1: got %0b exp 0", bready); end
        bready_mode = 1'b0;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_basic();
        logic ok;
        do_reset();
        wready = 1'b1;
        aw32(4'd3, 8'd3, 3'd2, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wvalid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_start: wvalid never rose"); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wvalid !== 1'b1 || wdata !== 32'(k) || wstrb !== 4'hF || wlast !== (k == 3) || wid !== 4'd3) begin
                fails++;
                $display("FAIL basic_beat%0d: v=%0b d=%h s=%h l=%0b id=%0d exp v=1 d=%h s=f l=%0b id=3",
                         k, wvalid, wdata, wstrb, wlast, wid, 32'(k), (k == 3));
            end
            tick();
        end
        tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL basic_end: wvalid %0b exp 0", wvalid); end
    endtask

    task automatic test_narrow();
        logic [7:0]  exp_strb [5];
        logic [63:0] exp_data [5];
        logic        exp_last [5];
        logic [3:0]  exp_id   [5];
        logic        ok;
        exp_strb = '{8'h08, 8'h30, 8'hC0, 8'h10, 8'h20};
        exp_data = '{64'h0, 64'h0000_0001_0000_0000, 64'h0, 64'h0000_0003_0000_0000, 64'h0};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_id   = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
        do_reset();
        h_wready = 1'b1;
        aw64(4'd1, 8'd2, 3'd1, 3'd3);
        aw64(4'd2, 8'd1, 3'd0, 3'd4);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (h_wvalid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL narrow_start: wvalid never rose"); end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (h_wvalid !== 1'b1 || h_wstrb !== exp_strb[k] || h_wdata !== exp_data[k] ||
                h_wlast !== exp_last[k] || h_wid !== exp_id[k]) begin
                fails++;
                $display("FAIL narrow_beat%0d: v=%0b s=%h d=%h l=%0b id=%0d exp v=1 s=%h d=%h l=%0b id=%0d",
                         k, h_wvalid, h_wstrb, h_wdata, h_wlast, h_wid,
                         exp_strb[k], exp_data[k], exp_last[k], exp_id[k]);
            end
            tick();
        end
        tests++; if (h_wvalid !== 1'b0 || h_wstrb !== 8'h00) begin
            fails++; $display("FAIL narrow_end: v=%0b s=%h exp 0/00", h_wvalid, h_wstrb);
        end
    endtask

    task automatic test_credit();
        logic [3:0] got_id [8];
        int nbeats;
        do_reset();
        for (int k = 0; k < 8; k++) got_id[k] = 4'hF;
        awvalid = 1'b1; awready = 1'b1; awlen = 8'd0; awsize = 3'd2; awaddr_lo = 2'd0;
        for (int i = 0; i < 4; i++) begin
            awid = 4'(i);
            tick();
            tests++; if (credit !== (i < 3)) begin
                fails++; $display("FAIL credit_push%0d: got %0b exp %0b", i, credit, (i < 3));
            end
        end
        awid = 4'd4;
        tick();
        awvalid = 1'b0; awready = 1'b0;
        tests++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL credit_overflow: got %0b exp 1", err_ovf); end
        wready = 1'b1;
        nbeats = 0;
        for (int c = 0; c < 20; c++) begin
            if (wvalid && wready) begin
                if (nbeats < 8) got_id[nbeats] = wid;
                nbeats++;
            end
            tick();
        end
        tests++; if (nbeats != 4) begin fails++; $display("FAIL credit_beats: got %0d exp 4", nbeats); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (got_id[k] !== 4'(k)) begin
                fails++; $display("FAIL credit_order%0d: got id %0d exp %0d", k, got_id[k], k);
            end
        end
        tests++; if (credit !== 1'b0) begin fails++; $display("FAIL credit_drained: got %0b exp 0", credit); end
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        tests++; if (credit !== 1'b1) begin fails++; $display("FAIL credit_after_b: got %0b exp 1", credit); end
        for (int i = 0; i < 3; i++) begin
            bvalid = 1'b1; tick(); bvalid = 1'b0;
        end
        tests++; if (err_bun !== 1'b0) begin fails++; $display("FAIL credit_b3: err_bunexp %0b exp 0", err_bun); end
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        tests++; if (err_bun !== 1'b1) begin fails++; $display("FAIL credit_bunexp: got %0b exp 1", err_bun); end
    endtask

    task automatic test_throttle();
        logic        pend, done;
        logic [31:0] p_data;
        logic [3:0]  p_strb;
        logic        p_last;
        int beats, bad_hold, bad_data, holds;
        do_reset();
        throttle_en = 1'b1;
        aw32(4'd5, 8'd7, 3'd2, 2'd0);
        pend = 1'b0; done = 1'b0; beats = 0; bad_hold = 0; bad_data = 0; holds = 0;
        p_data = 32'h0; p_strb = 4'h0; p_last = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (pend) begin
                if (wvalid !== 1'b1 || wdata !== p_data || wstrb !== p_strb || wlast !== p_last) bad_hold++;
            end
            wready = ~wready;
            if (wvalid && wready) begin
                if (wdata !== 32'(beats) || wstrb !== 4'hF || wid !== 4'd5) bad_data++;
                if (wlast !== (beats == 7)) bad_data++;
                beats++;
                if (wlast) done = 1'b1;
            end
            pend = wvalid && !wready;
            if (pend) holds++;
            p_data = wdata; p_strb = wstrb; p_last = wlast;
            tick();
        end
        throttle_en = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL throttle_timeout: last beat not seen"); end
        tests++; if (beats != 8) begin fails++; $display("FAIL throttle_beats: got %0d exp 8", beats); end
        tests++; if (bad_hold != 0) begin fails++; $display("FAIL throttle_hold: %0d unstable pending beats exp 0", bad_hold); end
        tests++; if (bad_data != 0) begin fails++; $display("FAIL throttle_data: %0d bad beats exp 0", bad_data); end
        tests++; if (holds == 0) begin fails++; $display("FAIL throttle_stall: %0d stalled beats exp >0", holds); end
        tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL throttle_end: wvalid %0b exp 0", wvalid); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int gaps, bad_data, bad_last, bad_id;
        do_reset();
        wready = 1'b1;
        aw32(4'd1, 8'd0, 3'd2, 2'd0);
        aw32(4'd2, 8'd255, 3'd2, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wvalid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_start: wvalid never rose"); end
        gaps = 0; bad_data = 0; bad_last = 0; bad_id = 0;
        for (int i = 0; i < 257; i++) begin
            if (wvalid !== 1'b1) gaps++;
            if (wdata !== 32'(i) || wstrb !== 4'hF) bad_data++;
            if (wlast !== (i == 0 || i == 256)) bad_last++;
            if (wid !== ((i == 0) ? 4'd1 : 4'd2)) bad_id++;
            tick();
        end
        tests++; if (gaps != 0) begin fails++; $display("FAIL b2b_gaps: %0d idle cycles exp 0", gaps); end
        tests++; if (bad_data != 0) begin fails++; $display("FAIL b2b_data: %0d bad beats exp 0", bad_data); end
        tests++; if (bad_last != 0) begin fails++; $display("FAIL b2b_last: %0d bad wlast exp 0", bad_last); end
        tests++; if (bad_id != 0) begin fails++; $display("FAIL b2b_id: %0d bad wid exp 0", bad_id); end
        tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL b2b_end: wvalid %0b exp 0", wvalid); end
    endtask

    task automatic test_srst_midburst();
        logic ok;
        do_reset();
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        tests++; if (err_bun !== 1'b1) begin fails++; $display("FAIL srst_bunexp_set: got %0b exp 1", err_bun); end
        wready = 1'b1;
        aw32(4'd2, 8'd15, 3'd2, 2'd0);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (wvalid === 1'b1 && wdata === 32'd5) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL srst_beat5: beat 5 not presented"); end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        tests++; if (wvalid !== 1'b0 || wlast !== 1'b0 || wdata !== 32'h0) begin
            fails++; $display("FAIL srst_outputs: v=%0b l=%0b d=%h exp 0/0/0", wvalid, wlast, wdata);
        end
        tests++; if (credit !== 1'b1 || err_bun !== 1'b0 || err_ovf !== 1'b0) begin
            fails++; $display("FAIL srst_state: credit=%0b bunexp=%0b ovf=%0b exp 1/0/0", credit, err_bun, err_ovf);
        end
        aw32(4'd4, 8'd0, 3'd2, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wvalid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        tests++; if (ok !== 1'b1 || wdata !== 32'h0 || wlast !== 1'b1 || wid !== 4'd4) begin
            fails++; $display("FAIL srst_restart: v=%0b d=%h l=%0b id=%0d exp 1/0/1/4", wvalid, wdata, wlast, wid);
        end
        tick();
        tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL srst_restart_end: wvalid %0b exp 0", wvalid); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_narrow();
        test_credit();
        test_throttle();
        test_back_to_back();
        test_srst_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
